// File: rtl/ysyx_25020047_mem_arb_if.sv
// Bundle of IFU, LSU and memory-side signals around the shared memory port arbiter.
// The arbiter uses the slave modport; whoever drives the requesters and the memory uses master.
interface ysyx_25020047_mem_arb_if #(
  parameter int ADDR_W = 32
);
  logic              ifu_valid;
  logic              ifu_ready;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_rvalid;
  logic              lsu_valid;
  logic              lsu_ready;
  logic [ADDR_W-1:0] lsu_addr;
  logic              lsu_wen;
  logic [31:0]       lsu_wdata;
  logic [3:0]        lsu_wmask;
  logic              lsu_rvalid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wmask;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;
  logic              mem_err;

  modport slave (
    input  ifu_valid, ifu_addr, lsu_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
           mem_ready, mem_rvalid, mem_rdata, mem_err,
    output ifu_ready, ifu_rvalid, lsu_ready, lsu_rvalid, rsp_rdata, rsp_err,
           mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

  modport master (
    output ifu_valid, ifu_addr, lsu_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
           mem_ready, mem_rvalid, mem_rdata, mem_err,
    input  ifu_ready, ifu_rvalid, lsu_ready, lsu_rvalid, rsp_rdata, rsp_err,
           mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/ysyx_25020047_mem_arb.sv
// IFU/LSU round-robin arbiter for the single memory port: one outstanding transaction,
// response routed to the owner, watchdog turns a hung bus access into an error response.
module ysyx_25020047_mem_arb #(
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 32
) (
  input logic clk,
  input logic rst_n,
  ysyx_25020047_mem_arb_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              last_lsu_q, last_lsu_d;
  logic              own_lsu_q, own_lsu_d;
  logic              mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_wen_q, mem_wen_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wmask_q, mem_wmask_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              ifu_rvalid_q, ifu_rvalid_d;
  logic              lsu_rvalid_q, lsu_rvalid_d;
  logic              grant_ifu, grant_lsu, timeout;

  // On a tie the requester that did not win last time gets the port.
  assign grant_ifu = (state_q == IDLE) && bus.ifu_valid && (!bus.lsu_valid || last_lsu_q);
  assign grant_lsu = (state_q == IDLE) && bus.lsu_valid && (!bus.ifu_valid || !last_lsu_q);
  // Fires one cycle early so the response lands exactly TIMEOUT cycles after mem_valid rose.
  assign timeout   = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_lsu_d   = last_lsu_q;
    own_lsu_d    = own_lsu_q;
    mem_valid_d  = mem_valid_q;
    mem_addr_d   = mem_addr_q;
    mem_wen_d    = mem_wen_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wmask_d  = mem_wmask_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    ifu_rvalid_d = 1'b0;
    lsu_rvalid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_ifu) begin
          mem_addr_d  = bus.ifu_addr;
          mem_wen_d   = 1'b0;
          mem_wdata_d = 32'h0;
          mem_wmask_d = 4'h0;
          own_lsu_d   = 1'b0;
          last_lsu_d  = 1'b0;
        end else if (grant_lsu) begin
          mem_addr_d  = bus.lsu_addr;
          mem_wen_d   = bus.lsu_wen;
          mem_wdata_d = bus.lsu_wdata;
          mem_wmask_d = bus.lsu_wmask;
          own_lsu_d   = 1'b1;
          last_lsu_d  = 1'b1;
        end
        if (grant_ifu || grant_lsu) begin
          mem_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = REQ;
        end
      end
      REQ, WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (state_q == WAIT && bus.mem_rvalid) begin
          rsp_rdata_d  = bus.mem_rdata;
          rsp_err_d    = bus.mem_err;
          ifu_rvalid_d = !own_lsu_q;
          lsu_rvalid_d = own_lsu_q;
          state_d      = RESP;
        end else if (timeout) begin
          mem_valid_d  = 1'b0;
          rsp_rdata_d  = 32'h0;
          rsp_err_d    = 1'b1;
          ifu_rvalid_d = !own_lsu_q;
          lsu_rvalid_d = own_lsu_q;
          state_d      = RESP;
        end else if (state_q == REQ && bus.mem_ready) begin
          mem_valid_d = 1'b0;
          state_d     = WAIT;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_lsu_q   <= 1'b1;
      own_lsu_q    <= 1'b0;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wen_q    <= 1'b0;
      mem_wdata_q  <= 32'h0;
      mem_wmask_q  <= 4'h0;
      rsp_rdata_q  <= 32'h0;
      rsp_err_q    <= 1'b0;
      ifu_rvalid_q <= 1'b0;
      lsu_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_lsu_q   <= last_lsu_d;
      own_lsu_q    <= own_lsu_d;
      mem_valid_q  <= mem_valid_d;
      mem_addr_q   <= mem_addr_d;
      mem_wen_q    <= mem_wen_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wmask_q  <= mem_wmask_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      ifu_rvalid_q <= ifu_rvalid_d;
      lsu_rvalid_q <= lsu_rvalid_d;
    end
  end

  assign bus.ifu_ready  = grant_ifu;
  assign bus.lsu_ready  = grant_lsu;
  assign bus.ifu_rvalid = ifu_rvalid_q;
  assign bus.lsu_rvalid = lsu_rvalid_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.mem_valid  = mem_valid_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wen    = mem_wen_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_wmask  = mem_wmask_q;
endmodule

// File: tb/tb_ysyx_25020047_mem_arb.sv
// Directed bench for the memory arbiter: fetch, delayed store, round robin, watchdog,
// bus error and mid-transaction reset, with hand-computed expectations.
module tb_ysyx_25020047_mem_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vecs = 0;
  int   errs = 0;

  ysyx_25020047_mem_arb_if #(.ADDR_W(32)) bus ();

  ysyx_25020047_mem_arb #(.TIMEOUT(8), .ADDR_W(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.ifu_valid = 0; bus.ifu_addr = 0;
    bus.lsu_valid = 0; bus.lsu_addr = 0; bus.lsu_wen = 0; bus.lsu_wdata = 0; bus.lsu_wmask = 0;
    bus.mem_ready = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0; bus.mem_err = 0;

    // reset state
    step();
    chk("rst_mem_valid", bus.mem_valid, 0);
    chk("rst_ifu_rvalid", bus.ifu_rvalid, 0);
    chk("rst_lsu_rvalid", bus.lsu_rvalid, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wen", bus.mem_wen, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_mem_wmask", bus.mem_wmask, 0);
    chk("rst_ifu_ready", bus.ifu_ready, 0);
    rst_n = 1;
    step();

    // single IFU fetch
    bus.ifu_valid = 1; bus.ifu_addr = 32'h8000_0000;
    #1;
    chk("f_ifu_ready", bus.ifu_ready, 1);
    chk("f_lsu_ready", bus.lsu_ready, 0);
    step();
    bus.ifu_valid = 0;
    chk("f_mem_valid", bus.mem_valid, 1);
    chk("f_mem_addr", bus.mem_addr, 64'h8000_0000);
    chk("f_mem_wen", bus.mem_wen, 0);
    chk("f_mem_wmask", bus.mem_wmask, 0);
    bus.mem_ready = 1;
    step();
    bus.mem_ready = 0;
    chk("f_mem_valid_drop", bus.mem_valid, 0);
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h0010_0093;
    step();
    bus.mem_rvalid = 0;
    chk("f_ifu_rvalid", bus.ifu_rvalid, 1);
    chk("f_lsu_rvalid", bus.lsu_rvalid, 0);
    chk("f_rsp_rdata", bus.rsp_rdata, 64'h0010_0093);
    chk("f_rsp_err", bus.rsp_err, 0);
    step();
    chk("f_ifu_rvalid_end", bus.ifu_rvalid, 0);
    chk("f_rsp_hold", bus.rsp_rdata, 64'h0010_0093);

    // LSU store with mem_ready delayed by 3 cycles
    bus.lsu_valid = 1; bus.lsu_addr = 32'h8000_1000; bus.lsu_wen = 1;
    bus.lsu_wdata = 32'hDEAD_BEEF; bus.lsu_wmask = 4'hF;
    #1;
    chk("s_lsu_ready", bus.lsu_ready, 1);
    step();
    bus.lsu_valid = 0; bus.lsu_addr = 32'h1111_1111; bus.lsu_wdata = 0; bus.lsu_wmask = 0;
    for (int i = 0; i < 3; i++) begin
      chk("s_mem_valid", bus.mem_valid, 1);
      chk("s_mem_addr", bus.mem_addr, 64'h8000_1000);
      chk("s_mem_wdata", bus.mem_wdata, 64'hDEAD_BEEF);
      chk("s_mem_wmask", bus.mem_wmask, 64'hF);
      chk("s_mem_wen", bus.mem_wen, 1);
      chk("s_lsu_ready_busy", bus.lsu_ready, 0);
      step();
    end
    chk("s_mem_valid_t4", bus.mem_valid, 1);
    bus.mem_ready = 1;
    step();
    bus.mem_ready = 0;
    chk("s_mem_valid_drop", bus.mem_valid, 0);
    chk("s_no_early_rvalid", bus.lsu_rvalid, 0);
    bus.mem_rvalid = 1; bus.mem_rdata = 0;
    step();
    bus.mem_rvalid = 0;
    chk("s_lsu_rvalid", bus.lsu_rvalid, 1);
    chk("s_ifu_rvalid", bus.ifu_rvalid, 0);
    chk("s_rsp_err", bus.rsp_err, 0);
    step();
    chk("s_lsu_rvalid_end", bus.lsu_rvalid, 0);

    // round robin after a fresh reset: IFU, LSU, IFU, LSU
    rst_n = 0;
    #1;
    rst_n = 1;
    step();
    bus.lsu_wen = 0;
    for (int k = 0; k < 4; k++) begin
      logic exp_ifu;
      exp_ifu = (k % 2 == 0);
      bus.ifu_valid = 1; bus.lsu_valid = 1;
      bus.ifu_addr = 32'h100 + k; bus.lsu_addr = 32'h200 + k;
      #1;
      chk("rr_ifu_ready", bus.ifu_ready, exp_ifu);
      chk("rr_lsu_ready", bus.lsu_ready, !exp_ifu);
      step();
      bus.ifu_valid = 0; bus.lsu_valid = 0;
      chk("rr_mem_addr", bus.mem_addr, exp_ifu ? 64'h100 + k : 64'h200 + k);
      bus.mem_ready = 1;
      step();
      bus.mem_ready = 0; bus.mem_rvalid = 1; bus.mem_rdata = k;
      step();
      bus.mem_rvalid = 0;
      chk("rr_ifu_rvalid", bus.ifu_rvalid, exp_ifu);
      chk("rr_lsu_rvalid", bus.lsu_rvalid, !exp_ifu);
      step();
    end

    // watchdog in WAIT: response 8 cycles after mem_valid rose
    bus.ifu_valid = 1; bus.ifu_addr = 32'h8000_0040;
    step();
    bus.ifu_valid = 0;
    chk("t_mem_valid", bus.mem_valid, 1);
    bus.mem_ready = 1;
    step();
    bus.mem_ready = 0;
    for (int i = 0; i < 7; i++) begin
      chk("t_no_rvalid", bus.ifu_rvalid, 0);
      step();
    end
    chk("t_ifu_rvalid", bus.ifu_rvalid, 1);
    chk("t_rsp_err", bus.rsp_err, 1);
    chk("t_rsp_rdata", bus.rsp_rdata, 0);
    step();
    bus.mem_rvalid = 1; bus.mem_rdata = 32'hAAAA_AAAA;
    step();
    bus.mem_rvalid = 0;
    chk("t_late_ifu", bus.ifu_rvalid, 0);
    chk("t_late_lsu", bus.lsu_rvalid, 0);
    chk("t_late_hold", bus.rsp_rdata, 0);
    step();
    chk("t_late_ifu2", bus.ifu_rvalid, 0);

    // watchdog in REQ: mem_valid held then dropped with the error response
    bus.lsu_valid = 1; bus.lsu_addr = 32'h8000_0080; bus.lsu_wen = 0;
    step();
    bus.lsu_valid = 0;
    for (int i = 0; i < 8; i++) begin
      chk("q_mem_valid", bus.mem_valid, 1);
      step();
    end
    chk("q_mem_valid_drop", bus.mem_valid, 0);
    chk("q_lsu_rvalid", bus.lsu_rvalid, 1);
    chk("q_rsp_err", bus.rsp_err, 1);
    step();

    // bus error on an LSU load
    bus.lsu_valid = 1; bus.lsu_addr = 32'h8000_2000; bus.lsu_wen = 0;
    step();
    bus.lsu_valid = 0; bus.mem_ready = 1;
    step();
    bus.mem_ready = 0; bus.mem_rvalid = 1; bus.mem_err = 1; bus.mem_rdata = 32'h1234_5678;
    step();
    bus.mem_rvalid = 0; bus.mem_err = 0;
    chk("e_lsu_rvalid", bus.lsu_rvalid, 1);
    chk("e_rsp_err", bus.rsp_err, 1);
    chk("e_rsp_rdata", bus.rsp_rdata, 64'h1234_5678);
    step();

    // reset while in WAIT, then a normal fetch
    bus.ifu_valid = 1; bus.ifu_addr = 32'h8000_0100;
    step();
    bus.ifu_valid = 0; bus.mem_ready = 1;
    step();
    bus.mem_ready = 0;
    rst_n = 0;
    #1;
    chk("r_mem_valid", bus.mem_valid, 0);
    chk("r_rsp_rdata", bus.rsp_rdata, 0);
    chk("r_rsp_err", bus.rsp_err, 0);
    chk("r_mem_addr", bus.mem_addr, 0);
    rst_n = 1;
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h5555_5555;
    step();
    bus.mem_rvalid = 0;
    chk("r_no_ifu_rvalid", bus.ifu_rvalid, 0);
    bus.ifu_valid = 1; bus.ifu_addr = 32'h8000_0200;
    #1;
    chk("r_ifu_ready", bus.ifu_ready, 1);
    step();
    bus.ifu_valid = 0;
    chk("r_mem_addr2", bus.mem_addr, 64'h8000_0200);
    bus.mem_ready = 1;
    step();
    bus.mem_ready = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h0000_0013;
    step();
    bus.mem_rvalid = 0;
    chk("r_ifu_rvalid", bus.ifu_rvalid, 1);
    chk("r_rsp_rdata2", bus.rsp_rdata, 64'h13);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/ysyx_25020047_mem_arb.md
# ysyx_25020047_mem_arb

Two-requester arbiter sharing the core's single memory port between the instruction fetch unit (IFU) and the load/store unit (LSU). It sits between the IFU/LSU and the memory-side bus and latches one request at a time. It drives the request onto the bus with a valid/ready handshake, waits for the memory response, and routes the response back to the requester that owns the transaction. A watchdog counter converts a hung memory transaction into an error response.

## Interface
- TIMEOUT, 255: maximum cycles from `mem_valid` first high to `mem_rvalid`; counter width is $clog2(TIMEOUT+1).
- ADDR_W, 32: address width.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- ifu_valid  in  1  IFU fetch request (read-only).
- ifu_ready  out  1  IFU request accepted this cycle.
- ifu_addr  in  ADDR_W  fetch address.
- ifu_rvalid  out  1  one-cycle pulse: response for IFU on `rsp_rdata`/`rsp_err`.
- lsu_valid  in  1  LSU load/store request.
- lsu_ready  out  1  LSU request accepted this cycle.
- lsu_addr  in  ADDR_W  load/store address.
- lsu_wen  in  1  1 = store, 0 = load.
- lsu_wdata  in  32  store data.
- lsu_wmask  in  4  store byte enables.
- lsu_rvalid  out  1  one-cycle pulse: response for LSU.
- rsp_rdata  out  32  response data, shared by both requesters.
- rsp_err  out  1  response error, shared by both requesters; qualified by the `*_rvalid` pulses.
- mem_valid  out  1  bus request valid.
- mem_ready  in  1  bus accepts the request.
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  ADDR_W/1/32/4  latched request fields.
- mem_rvalid  in  1  bus response valid; stores also receive one response (write ack).
- mem_rdata  in  32  bus read data.
- mem_err  in  1  bus error for the current response.

## Operation
- States:
  - IDLE: accepts a new request.
  - REQ: drives `mem_valid`.
  - WAIT: waits for `mem_rvalid`.
  - RESP: pulses the response.
- IDLE, one requester valid: assert that requester's `*_ready`. On valid&ready, latch addr/wen/wdata/wmask and owner, then go to REQ.
  - IFU requests are latched with `wen=0`, `wmask=0`, `wdata=0`.
- IDLE, both requesters valid: round-robin. Grant the requester not granted last; only one `*_ready` is high.
- `last_owner` updates on every grant.
- REQ: `mem_valid=1` with latched fields, held stable until `mem_ready`. On `mem_valid&mem_ready`, go to WAIT.
- WAIT: on `mem_rvalid`, register `mem_rdata` and `mem_err` into `rsp_rdata`/`rsp_err`, then go to RESP.
- RESP: owner's `*_rvalid=1` for exactly one cycle, then go to IDLE.
- `*_ready` is 0 in REQ, WAIT and RESP.
- Watchdog:
  - Counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When the count reaches TIMEOUT without a response: `rsp_rdata=0`, `rsp_err=1`, go to RESP.
  - If the timeout fires while in REQ, `mem_valid` drops.
- `mem_rvalid` outside WAIT (late response after a timeout, spurious pulse) is ignored. The FSM does not change state.
- `mem_rvalid` in the same cycle the counter reaches TIMEOUT: the real response wins and `rsp_err=mem_err`.
- `rsp_rdata`/`rsp_err` hold their values outside RESP.

## Timing
- Reset (async assert):
  - state=IDLE, `last_owner`=LSU, so IFU wins the first tie.
  - Counter=0.
  - `mem_valid`, `ifu_ready`, `lsu_ready`, `ifu_rvalid`, `lsu_rvalid`, `rsp_err` = 0.
  - `rsp_rdata`, `mem_addr`, `mem_wdata` = 0; `mem_wen`, `mem_wmask` = 0.
- `*_ready` is combinational from state and `*_valid` in IDLE.
- Request accepted at cycle T:
  - `mem_valid` high at T+1.
  - With `mem_ready` at T+1 and `mem_rvalid` at T+2, `*_rvalid` pulses at T+3.
  - Next grant possible at T+4. Minimum turnaround is 4 cycles per transaction.
- A requester may drop `*_valid` at any time before acceptance; nothing is latched.
- Reset asserted mid-transaction: the transaction is abandoned, no `*_rvalid` is issued, and `mem_valid` drops immediately.

## Test plan
- Single IFU fetch, addr 0x80000000, memory returns `mem_ready` at T+1 and 0x00100093 at T+2 -> `ifu_rvalid` pulse at T+3 with `rsp_rdata`=0x00100093, `rsp_err`=0; `lsu_rvalid` stays 0.
- LSU store, addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF, `mem_ready` delayed 3 cycles -> `mem_valid`/fields stable for all 3 cycles; single `lsu_rvalid` after the ack.
- IFU and LSU valid simultaneously for 4 transactions after reset -> grants in order IFU, LSU, IFU, LSU.
- `mem_ready` high, `mem_rvalid` never arrives, TIMEOUT=8 -> `*_rvalid` with `rsp_err`=1, `rsp_rdata`=0 exactly 8 cycles after `mem_valid` rose. A late `mem_rvalid` then produces no pulse.
- `mem_err`=1 with `mem_rdata`=0x12345678 on an LSU load -> `lsu_rvalid` with `rsp_err`=1, `rsp_rdata`=0x12345678.
- `rst_n` pulsed low while in WAIT -> all outputs 0 immediately; next IFU request is served normally.
